// File: rtl/add_sub_seq.sv
// add_sub_seq: multi-cycle chunked adder/subtractor with valid/ready on both sides.
// Optional signed saturation of S on overflow when ADDSUB_SAT_EN is defined.
`default_nettype none

module add_sub_seq #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             M,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             V,
   output logic             Z,
   output logic             N
);

   localparam int STEPS = WIDTH / CHUNK;
   localparam int CW    = $clog2(STEPS) + 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   generate
      if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
         $error("add_sub_seq: CHUNK must be in 1..WIDTH and divide WIDTH");
      end
   endgenerate

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] s_q;
   logic             cout_q, v_q, z_q, n_q;

   logic             accept_d, step_d, last_d;
   logic [CHUNK:0]   sum_d;
   logic [WIDTH-1:0] res_d;
   logic             v_d;
   logic [WIDTH-1:0] s_fin_d;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept_d)  state_d = RUN;
         RUN:     if (last_d)    state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   // Output / control decode
   always_comb begin
      in_ready = (state_q == IDLE) && !rst;
      accept_d = in_valid && in_ready;
      step_d   = (state_q == RUN);
      last_d   = step_d && (cnt_q == LAST_STEP);
   end

   // The operand registers shift right each step, so the active chunk is always the low slice.
   assign sum_d = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};

   // Carry into the MSB is recovered from the top bit's sum, then XORed with carry out.
   assign v_d = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ sum_d[CHUNK-1] ^ sum_d[CHUNK];

   generate
      if (CHUNK == WIDTH) begin : g_one_step
         assign res_d = sum_d[CHUNK-1:0];
      end else begin : g_multi_step
         logic [WIDTH-CHUNK-1:0] part_q;

         assign res_d = {sum_d[CHUNK-1:0], part_q};

         always_ff @(posedge clk) begin
            if (rst)         part_q <= '0;
            else if (step_d) part_q <= res_d[WIDTH-1:CHUNK];
         end
      end
   endgenerate

`ifdef ADDSUB_SAT_EN
   logic a_sign_q;

   always_ff @(posedge clk) begin
      if (rst)           a_sign_q <= 1'b0;
      else if (accept_d) a_sign_q <= A[WIDTH-1];
   end

   assign s_fin_d = !v_d     ? res_d :
                    a_sign_q ? {1'b1, {(WIDTH-1){1'b0}}} :
                               {1'b0, {(WIDTH-1){1'b1}}};
`else
   assign s_fin_d = res_d;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q         <= '0;
         b_q         <= '0;
         carry_q     <= 1'b0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         s_q         <= '0;
         cout_q      <= 1'b0;
         v_q         <= 1'b0;
         z_q         <= 1'b0;
         n_q         <= 1'b0;
      end else begin
         if (accept_d) begin
            a_q     <= A;
            b_q     <= M ? ~B : B;
            carry_q <= M;
            cnt_q   <= '0;
         end else if (step_d) begin
            a_q     <= a_q >> CHUNK;
            b_q     <= b_q >> CHUNK;
            carry_q <= sum_d[CHUNK];
            cnt_q   <= cnt_q + CW'(1);
         end
         if (last_d) begin
            out_valid_q <= 1'b1;
            s_q         <= s_fin_d;
            cout_q      <= sum_d[CHUNK];
            v_q         <= v_d;
            z_q         <= (s_fin_d == '0);
            n_q         <= s_fin_d[WIDTH-1];
         end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign S         = s_q;
   assign Cout      = cout_q;
   assign V         = v_q;
   assign Z         = z_q;
   assign N         = n_q;

endmodule

`default_nettype wire

// File: tb/tb_add_sub_seq.sv
// tb_add_sub_seq: randomized scoreboard bench for add_sub_seq (CHUNK=16 main, CHUNK=1/64 side units).
`default_nettype none

module tb_add_sub_seq;

   localparam int W     = 64;
   localparam int CH    = 16;
   localparam int STEPS = W / CH;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic         x_valid = 1'b0;
   logic         M = 1'b0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;

   logic         in_ready, out_valid, Cout, V, Z, N;
   logic [W-1:0] S;
   logic         x1_ir, x1_ov, x1_c, x1_v, x1_z, x1_n;
   logic [W-1:0] x1_s;
   logic         x64_ir, x64_ov, x64_c, x64_v, x64_z, x64_n;
   logic [W-1:0] x64_s;

   add_sub_seq #(.WIDTH(W), .CHUNK(CH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .M(M), .out_valid(out_valid), .out_ready(out_ready),
      .S(S), .Cout(Cout), .V(V), .Z(Z), .N(N));

   add_sub_seq #(.WIDTH(W), .CHUNK(1)) u_x1 (
      .clk(clk), .rst(rst), .in_valid(x_valid), .in_ready(x1_ir),
      .A(A), .B(B), .M(M), .out_valid(x1_ov), .out_ready(1'b1),
      .S(x1_s), .Cout(x1_c), .V(x1_v), .Z(x1_z), .N(x1_n));

   add_sub_seq #(.WIDTH(W), .CHUNK(W)) u_x64 (
      .clk(clk), .rst(rst), .in_valid(x_valid), .in_ready(x64_ir),
      .A(A), .B(B), .M(M), .out_valid(x64_ov), .out_ready(1'b1),
      .S(x64_s), .Cout(x64_c), .V(x64_v), .Z(x64_z), .N(x64_n));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] s;
      logic         c, v, z, n;
      int           acc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;
   bit   rdy_rand = 1'b0;
   bit   prev_ov = 1'b0;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   task automatic fail_now(input string nm);
      checks++;
      failures++;
      $display("FAIL %s: timed out (t=%0t)", nm, $time);
   endtask

   // Reference: plain unsigned and sign-extended arithmetic on the whole words.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
      exp_t              e;
      logic [W:0]        u;
      logic signed [W:0] sg;
      if (!m) begin
         u   = {1'b0, a} + {1'b0, b};
         e.s = u[W-1:0];
         e.c = u[W];
         sg  = $signed({a[W-1], a}) + $signed({b[W-1], b});
      end else begin
         e.s = a - b;
         e.c = (a >= b);
         sg  = $signed({a[W-1], a}) - $signed({b[W-1], b});
      end
      e.v = (sg[W] != sg[W-1]);
`ifdef ADDSUB_SAT_EN
      if (e.v) e.s = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
      e.z   = (e.s == '0);
      e.n   = e.s[W-1];
      e.acc = 0;
      return e;
   endfunction

   function automatic logic [W-1:0] rnd();
      logic [W-1:0] r;
      case ($urandom_range(0, 7))
         0:       r = '0;
         1:       r = '1;
         2:       r = {1'b0, {(W-1){1'b1}}};
         3:       r = {1'b1, {(W-1){1'b0}}};
         default: r = {$urandom(), $urandom()};
      endcase
      return r;
   endfunction

   always @(negedge clk) if (rdy_rand) out_ready = 1'($urandom_range(0, 1));

   // Monitor: compares whatever the DUT presents against the head of the scoreboard.
   always @(negedge clk) begin
      #1;
      if (!rst && out_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_out_valid", out_valid, 1'b0);
         end else begin
            if (!prev_ov) chk("latency", W'(cyc - q[0].acc), W'(STEPS));
            chk("S", S, q[0].s);
            chk("Cout", Cout, q[0].c);
            chk("V", V, q[0].v);
            chk("Z", Z, q[0].z);
            chk("N", N, q[0].n);
            chk("in_ready_busy", in_ready, 1'b0);
            if (out_ready) void'(q.pop_front());
         end
      end
      prev_ov = out_valid;
   end

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
      exp_t e;
      bit   done = 1'b0;
      e = model(a, b, m);
      @(negedge clk);
      in_valid = 1'b1; A = a; B = b; M = m;
      for (int t = 0; t < 300 && !done; t++) begin
         #1;
         if (in_ready) begin
            e.acc = cyc + 1;
            q.push_back(e);
            done = 1'b1;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      if (!done) fail_now("issue_accept");
   endtask

   task automatic drain();
      bit done = 1'b0;
      for (int t = 0; t < 1000 && !done; t++) begin
         @(negedge clk); #2;
         if (q.size() == 0 && in_ready) done = 1'b1;
      end
      if (!done) fail_now("drain");
   endtask

   task automatic run_x(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
      exp_t e;
      bit   g1 = 1'b0;
      bit   g64 = 1'b0;
      e = model(a, b, m);
      @(negedge clk);
      A = a; B = b; M = m; x_valid = 1'b1;
      #1;
      chk("x_in_ready", {x1_ir, x64_ir}, 2'b11);
      @(negedge clk);
      x_valid = 1'b0;
      for (int t = 0; t < 200 && !(g1 && g64); t++) begin
         #1;
         if (x1_ov && !g1) begin
            chk("x1_S", x1_s, e.s); chk("x1_Cout", x1_c, e.c); chk("x1_V", x1_v, e.v);
            g1 = 1'b1;
         end
         if (x64_ov && !g64) begin
            chk("x64_S", x64_s, e.s); chk("x64_Cout", x64_c, e.c); chk("x64_V", x64_v, e.v);
            g64 = 1'b1;
         end
         @(negedge clk);
      end
      if (!(g1 && g64)) fail_now("x_result");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit seen;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_S", S, '0);
      chk("rst_flags", {Cout, V, Z, N}, 4'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("idle_in_ready", in_ready, 1'b1);

      out_ready = 1'b1;
      issue(64'd1, 64'd1, 1'b0);
      issue('1, 64'd1, 1'b0);
      issue(64'd0, 64'd1, 1'b1);
      issue(64'h0A, 64'h05, 1'b1);
      issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      issue(64'h8000_0000_0000_0000, 64'd1, 1'b1);
      issue(64'h1234, 64'h1234, 1'b1);
      drain();

      // Back-pressure: result held in DONE while new operands are offered.
      out_ready = 1'b0;
      issue(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0);
      seen = 1'b0;
      for (int t = 0; t < 50 && !seen; t++) begin
         @(negedge clk); #2;
         seen = out_valid;
      end
      if (!seen) fail_now("hold_out_valid");
      repeat (5) begin
         @(negedge clk);
         in_valid = 1'b1; A = rnd(); B = rnd(); M = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain();
      issue(64'd100, 64'd58, 1'b1);
      drain();

      // Reset in the middle of RUN discards the partial result.
      issue(rnd(), rnd(), 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_in_ready", in_ready, 1'b1);
      chk("midrst_S", S, '0);
      chk("midrst_flags", {Cout, V, Z, N}, 4'b0);
      issue(64'd7, 64'd9, 1'b1);
      drain();

      rdy_rand = 1'b1;
      for (int i = 0; i < 40; i++) issue(rnd(), rnd(), 1'($urandom_range(0, 1)));
      drain();
      rdy_rand = 1'b0;
      @(negedge clk);
      out_ready = 1'b1;

      run_x(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      run_x(64'd0, 64'd1, 1'b1);
      for (int i = 0; i < 6; i++) run_x(rnd(), rnd(), 1'($urandom_range(0, 1)));

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
